// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch blocks.
//
// Contents:
//   REG_*              Avalon-MM register offsets of the control slave
//   KEY_COLOR_DEFAULT  RGB565 value treated as transparent
//   SPRITE_W_DEFAULT   default sprite edge length in pixels
//   sprite_cfg_t       one copy of the sprite placement/enable settings
//   rgb565_to_rgb888   colour expansion by MSB replication
package sprite_pkg;

    localparam logic [1:0] REG_X      = 2'd0;
    localparam logic [1:0] REG_Y      = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [15:0] KEY_COLOR_DEFAULT = 16'hF81F;
    localparam int          SPRITE_W_DEFAULT  = 16;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } sprite_cfg_t;

    // Replicating the top bits of each channel into the new LSBs maps full
    // scale to full scale (1F -> FF, 3F -> FF) and zero to zero.
    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] c);
        return {c[15:11], c[15:13],
                c[10:5],  c[10:9],
                c[4:0],   c[4:2]};
    endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Sprite bounding-box test and ROM address generation.
//
// Decides whether the current raster pixel lies inside a SPRITE_W x SPRITE_W
// box whose top-left corner is (org_x_i, org_y_i), and if so forms the
// row-major address of that pixel within a 16x16 sprite ROM.
//
// Ports:
//   pix_valid_i   raster pixel is valid this cycle
//   pix_x_i/y_i   raster pixel coordinates (10 bit)
//   enable_i      sprite enabled
//   org_x_i/y_i   sprite origin (10 bit)
//   hit_o         pixel lies inside the enabled sprite box
//   rom_addr_o    {dy[3:0], dx[3:0]} on a hit, otherwise 0
module sprite_hit_calc #(
    parameter int SPRITE_W = 16
) (
    input  logic       pix_valid_i,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    input  logic       enable_i,
    input  logic [9:0] org_x_i,
    input  logic [9:0] org_y_i,
    output logic       hit_o,
    output logic [7:0] rom_addr_o
);

    localparam logic [10:0] SPAN = 11'(SPRITE_W);

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_x;
    logic        in_y;

    // Differences are taken at 11 bits so that a pixel left of / above the
    // origin wraps to a value of at least 1025, which can never fall inside
    // the box. Parts of the sprite past column/row 1023 simply never hit;
    // there is no wrap back to coordinate 0.
    assign dx = {1'b0, pix_x_i} - {1'b0, org_x_i};
    assign dy = {1'b0, pix_y_i} - {1'b0, org_y_i};

    assign in_x = (dx < SPAN);
    assign in_y = (dy < SPAN);

    assign hit_o      = pix_valid_i & enable_i & in_x & in_y;
    assign rom_addr_o = hit_o ? {dy[3:0], dx[3:0]} : 8'd0;

endmodule

// File: rtl/bomb_sprite_fetch.sv
// Bomb sprite fetch: overlays one 16x16 RGB565 sprite onto the raster.
//
// A host programs the sprite position and enable through a small Avalon-MM
// slave. Written values are staged and only take effect at frame_start so a
// sprite never tears mid-frame. Each valid raster pixel is tested against the
// active sprite box; on a hit the sprite ROM is addressed and, two cycles
// later, the pixel result is presented with transparent (key colour) texels
// reported as misses.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   avs_*                   control slave (0=X, 1=Y, 2=CTRL.en, 3=STATUS.pending)
//   frame_start             one-cycle pulse at start of vertical blank
//   pix_valid, pix_x, pix_y current raster pixel
//   rom_address/chipselect/clken, rom_readdata
//                           256x16 sprite ROM, data one cycle after address
//   out_valid, out_hit, out_rgb
//                           pixel result, RGB888, two cycles after pix_valid
module bomb_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int          SPRITE_W  = SPRITE_W_DEFAULT,
    parameter logic [15:0] KEY_COLOR = KEY_COLOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic        avs_chipselect,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,

    input  logic        frame_start,

    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,

    output logic [7:0]  rom_address,
    output logic        rom_chipselect,
    output logic        rom_clken,
    input  logic [15:0] rom_readdata,

    output logic        out_valid,
    output logic        out_hit,
    output logic [23:0] out_rgb
);

    sprite_cfg_t staged_q, staged_d;
    sprite_cfg_t active_q, active_d;
    logic        pending_q, pending_d;

    logic        wr_en;
    logic        wr_cfg;

    logic        hit0;
    logic [7:0]  addr0;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_hit_q,   s1_hit_d;

    logic        out_valid_q, out_valid_d;
    logic        out_hit_q,   out_hit_d;
    logic [23:0] out_rgb_q,   out_rgb_d;

    // Only X/Y carry 10 significant bits and CTRL carries one.
    logic        unused_wdata;
    assign unused_wdata = ^avs_writedata[15:10];

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    assign wr_en  = avs_chipselect & avs_write;
    assign wr_cfg = wr_en & (avs_address != REG_STATUS);

    always_comb begin
        staged_d  = staged_q;
        active_d  = active_q;
        pending_d = pending_q;

        if (wr_en) begin
            case (avs_address)
                REG_X:    staged_d.x  = avs_writedata[9:0];
                REG_Y:    staged_d.y  = avs_writedata[9:0];
                REG_CTRL: staged_d.en = avs_writedata[0];
                default:  ;
            endcase
        end

        if (wr_cfg) begin
            pending_d = 1'b1;
        end

        // Copy from staged_d rather than staged_q so that a write landing on
        // the frame_start cycle is applied immediately and leaves nothing
        // pending.
        if (frame_start) begin
            active_d  = staged_d;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staged_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            staged_q  <= staged_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Zero-wait-state read: data is returned combinationally in the cycle
    // the read is presented. Reads show the staged (host-visible) values.
    always_comb begin
        avs_readdata = 16'd0;
        if (avs_chipselect && avs_read) begin
            case (avs_address)
                REG_X:      avs_readdata = {6'd0, staged_q.x};
                REG_Y:      avs_readdata = {6'd0, staged_q.y};
                REG_CTRL:   avs_readdata = {15'd0, staged_q.en};
                REG_STATUS: avs_readdata = {15'd0, pending_q};
                default:    avs_readdata = 16'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: bounds check and ROM address (combinational)
    // ------------------------------------------------------------------
    sprite_hit_calc #(
        .SPRITE_W (SPRITE_W)
    ) u_hit_calc (
        .pix_valid_i (pix_valid),
        .pix_x_i     (pix_x),
        .pix_y_i     (pix_y),
        .enable_i    (active_q.en),
        .org_x_i     (active_q.x),
        .org_y_i     (active_q.y),
        .hit_o       (hit0),
        .rom_addr_o  (addr0)
    );

    assign rom_address    = addr0;
    assign rom_chipselect = hit0;
    assign rom_clken      = 1'b1;

    // ------------------------------------------------------------------
    // Stage 1 runs alongside the ROM's address register; stage 2 sees the
    // ROM word for the same pixel and applies the transparency key.
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = pix_valid;
        s1_hit_d    = hit0;

        out_valid_d = s1_valid_q;
        out_hit_d   = s1_hit_q & (rom_readdata != KEY_COLOR);
        out_rgb_d   = out_hit_d ? rgb565_to_rgb888(rom_readdata) : 24'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_rgb_q   <= 24'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_rgb   = out_rgb_q;

endmodule

// File: tb/tb_bomb_sprite_fetch.sv
module tb_bomb_sprite_fetch;

    logic        clk;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic        avs_read;
    logic        avs_chipselect;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [15:0] rom_readdata;
    logic        out_valid;
    logic        out_hit;
    logic [23:0] out_rgb;

    logic [15:0] rom_word;

    int checks = 0;
    int errors = 0;

    logic [7:0]  r_addr;
    logic        r_cs;
    logic        r_ov;
    logic        r_oh;
    logic [23:0] r_rgb;
    logic [15:0] r_data;

    bomb_sprite_fetch #(
        .SPRITE_W  (16),
        .KEY_COLOR (16'hF81F)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_read       (avs_read),
        .avs_chipselect (avs_chipselect),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .frame_start    (frame_start),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .rom_address    (rom_address),
        .rom_chipselect (rom_chipselect),
        .rom_clken      (rom_clken),
        .rom_readdata   (rom_readdata),
        .out_valid      (out_valid),
        .out_hit        (out_hit),
        .out_rgb        (out_rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM model: one word of latency, every location holds rom_word.
    always @(posedge clk) begin
        if (rom_chipselect && rom_clken) rom_readdata <= rom_word;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = a;
        avs_writedata  = d;
        tick();
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        avs_address    = a;
        #1;
        d = avs_readdata;
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Presents one pixel, captures the combinational ROM outputs, then the
    // result two clock edges later.
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y,
                             output logic [7:0] addr, output logic cs,
                             output logic ov, output logic oh,
                             output logic [23:0] rgb);
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        #1;
        addr = rom_address;
        cs   = rom_chipselect;
        tick();
        pix_valid = 1'b0;
        tick();
        ov  = out_valid;
        oh  = out_hit;
        rgb = out_rgb;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0 || out_rgb !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b h=%0b rgb=%h want 0 0 000000",
                     out_valid, out_hit, out_rgb);
        end
        checks++;
        if (rom_address !== 8'd0 || rom_chipselect !== 1'b0 || rom_clken !== 1'b1) begin
            errors++;
            $display("FAIL reset_rom got addr=%h cs=%0b clken=%0b want 00 0 1",
                     rom_address, rom_chipselect, rom_clken);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), r_data);
            checks++;
            if (r_data !== 16'd0) begin
                errors++;
                $display("FAIL reset_reg%0d got %h want 0000", a, r_data);
            end
        end
        tick();
    endtask

    task automatic test_basic_hit();
        bus_write(2'd0, 16'd100);
        bus_write(2'd1, 16'd50);
        bus_write(2'd2, 16'd1);
        bus_read(2'd3, r_data);
        checks++;
        if (r_data !== 16'd1) begin
            errors++;
            $display("FAIL status_after_write got %h want 0001", r_data);
        end
        pulse_frame();
        bus_read(2'd3, r_data);
        checks++;
        if (r_data !== 16'd0) begin
            errors++;
            $display("FAIL status_after_frame got %h want 0000", r_data);
        end
        tick();
        rom_word = 16'hFFFF;

        run_pixel(10'd100, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'd0 || r_cs !== 1'b1) begin
            errors++;
            $display("FAIL corner_addr got addr=%h cs=%0b want 00 1", r_addr, r_cs);
        end
        checks++;
        if (r_ov !== 1'b1 || r_oh !== 1'b1 || r_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL corner_out got v=%0b h=%0b rgb=%h want 1 1 ffffff", r_ov, r_oh, r_rgb);
        end

        run_pixel(10'd115, 10'd65, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'd255 || r_cs !== 1'b1 || r_oh !== 1'b1 || r_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL far_corner got addr=%h cs=%0b h=%0b rgb=%h want ff 1 1 ffffff",
                     r_addr, r_cs, r_oh, r_rgb);
        end

        run_pixel(10'd116, 10'd65, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'd0 || r_cs !== 1'b0 || r_ov !== 1'b1 || r_oh !== 1'b0 || r_rgb !== 24'd0) begin
            errors++;
            $display("FAIL right_of_box got addr=%h cs=%0b v=%0b h=%0b rgb=%h want 00 0 1 0 000000",
                     r_addr, r_cs, r_ov, r_oh, r_rgb);
        end

        run_pixel(10'd99, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'd0 || r_cs !== 1'b0 || r_ov !== 1'b1 || r_oh !== 1'b0 || r_rgb !== 24'd0) begin
            errors++;
            $display("FAIL left_of_box got addr=%h cs=%0b v=%0b h=%0b rgb=%h want 00 0 1 0 000000",
                     r_addr, r_cs, r_ov, r_oh, r_rgb);
        end

        run_pixel(10'd100, 10'd66, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_cs !== 1'b0 || r_oh !== 1'b0) begin
            errors++;
            $display("FAIL below_box got cs=%0b h=%0b want 0 0", r_cs, r_oh);
        end
    endtask

    task automatic test_key_color();
        rom_word = 16'hF81F;
        run_pixel(10'd105, 10'd55, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'h55 || r_ov !== 1'b1 || r_oh !== 1'b0 || r_rgb !== 24'd0) begin
            errors++;
            $display("FAIL key_transparent got addr=%h v=%0b h=%0b rgb=%h want 55 1 0 000000",
                     r_addr, r_ov, r_oh, r_rgb);
        end
        rom_word = 16'hF800;
        run_pixel(10'd105, 10'd55, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_ov !== 1'b1 || r_oh !== 1'b1 || r_rgb !== 24'hFF0000) begin
            errors++;
            $display("FAIL red_expand got v=%0b h=%0b rgb=%h want 1 1 ff0000", r_ov, r_oh, r_rgb);
        end
        rom_word = 16'h0812;
        run_pixel(10'd101, 10'd51, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'h11 || r_oh !== 1'b1 || r_rgb !== 24'h080094) begin
            errors++;
            $display("FAIL mixed_expand got addr=%h h=%0b rgb=%h want 11 1 080094", r_addr, r_oh, r_rgb);
        end
    endtask

    task automatic test_staging();
        rom_word = 16'hF800;
        bus_write(2'd0, 16'd200);
        bus_read(2'd3, r_data);
        checks++;
        if (r_data !== 16'd1) begin
            errors++;
            $display("FAIL stage_pending got %h want 0001", r_data);
        end
        bus_read(2'd0, r_data);
        checks++;
        if (r_data !== 16'd200) begin
            errors++;
            $display("FAIL stage_readback got %h want 00c8", r_data);
        end
        tick();
        run_pixel(10'd100, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_oh !== 1'b1) begin
            errors++;
            $display("FAIL stage_old_x got h=%0b want 1", r_oh);
        end
        run_pixel(10'd200, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_oh !== 1'b0 || r_cs !== 1'b0) begin
            errors++;
            $display("FAIL stage_new_x_early got h=%0b cs=%0b want 0 0", r_oh, r_cs);
        end
        pulse_frame();
        bus_read(2'd3, r_data);
        checks++;
        if (r_data !== 16'd0) begin
            errors++;
            $display("FAIL stage_cleared got %h want 0000", r_data);
        end
        tick();
        run_pixel(10'd200, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'd0 || r_oh !== 1'b1 || r_rgb !== 24'hFF0000) begin
            errors++;
            $display("FAIL stage_new_x got addr=%h h=%0b rgb=%h want 00 1 ff0000", r_addr, r_oh, r_rgb);
        end
        run_pixel(10'd100, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_oh !== 1'b0) begin
            errors++;
            $display("FAIL stage_old_x_gone got h=%0b want 0", r_oh);
        end
    endtask

    task automatic test_right_edge();
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = 2'd0;
        avs_writedata  = 16'd1020;
        frame_start    = 1'b1;
        tick();
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        frame_start    = 1'b0;
        bus_read(2'd3, r_data);
        checks++;
        if (r_data !== 16'd0) begin
            errors++;
            $display("FAIL edge_status got %h want 0000", r_data);
        end
        tick();
        rom_word = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            run_pixel(10'(1020 + i), 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
            checks++;
            if (r_addr !== 8'(i) || r_cs !== 1'b1 || r_oh !== 1'b1) begin
                errors++;
                $display("FAIL edge_x%0d got addr=%h cs=%0b h=%0b want %h 1 1",
                         1020 + i, r_addr, r_cs, r_oh, 8'(i));
            end
        end
        run_pixel(10'd0, 10'd50, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_addr !== 8'd0 || r_cs !== 1'b0 || r_ov !== 1'b1 || r_oh !== 1'b0) begin
            errors++;
            $display("FAIL edge_nowrap got addr=%h cs=%0b v=%0b h=%0b want 00 0 1 0",
                     r_addr, r_cs, r_ov, r_oh);
        end
    endtask

    task automatic test_back_to_back();
        rom_word  = 16'h07E0;
        pix_valid = 1'b1;
        pix_y     = 10'd50;
        pix_x     = 10'd1019;
        tick();
        pix_x = 10'd1020;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_p0 got v=%0b h=%0b want 1 0", out_valid, out_hit);
        end
        pix_x = 10'd1021;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_rgb !== 24'h00FF00) begin
            errors++;
            $display("FAIL b2b_p1 got v=%0b h=%0b rgb=%h want 1 1 00ff00", out_valid, out_hit, out_rgb);
        end
        pix_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_rgb !== 24'h00FF00) begin
            errors++;
            $display("FAIL b2b_p2 got v=%0b h=%0b rgb=%h want 1 1 00ff00", out_valid, out_hit, out_rgb);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got v=%0b h=%0b want 0 0", out_valid, out_hit);
        end
    endtask

    task automatic test_frame_edge_inflight();
        rom_word = 16'hFFFF;
        bus_write(2'd0, 16'd500);
        pix_valid   = 1'b1;
        pix_x       = 10'd1020;
        pix_y       = 10'd50;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1) begin
            errors++;
            $display("FAIL edge_inflight_old got v=%0b h=%0b want 1 1", out_valid, out_hit);
        end
        pix_x = 10'd500;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0) begin
            errors++;
            $display("FAIL edge_after_frame_old_x got v=%0b h=%0b want 1 0", out_valid, out_hit);
        end
        pix_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1) begin
            errors++;
            $display("FAIL edge_after_frame_new_x got v=%0b h=%0b want 1 1", out_valid, out_hit);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        rom_word  = 16'hFFFF;
        pix_valid = 1'b1;
        pix_x     = 10'd500;
        pix_y     = 10'd50;
        tick();
        pix_x = 10'd501;
        tick();
        pix_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got v=%0b h=%0b want 1 1", out_valid, out_hit);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0 || out_rgb !== 24'd0) begin
            errors++;
            $display("FAIL rst_async got v=%0b h=%0b rgb=%h want 0 0 000000", out_valid, out_hit, out_rgb);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_next got v=%0b want 0", out_valid);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), r_data);
            checks++;
            if (r_data !== 16'd0) begin
                errors++;
                $display("FAIL rst_reg%0d got %h want 0000", a, r_data);
            end
        end
        tick();
        pix_valid = 1'b1;
        pix_x     = 10'd0;
        pix_y     = 10'd0;
        tick();
        pix_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_latency1 got v=%0b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0) begin
            errors++;
            $display("FAIL rst_latency2 got v=%0b h=%0b want 1 0", out_valid, out_hit);
        end
        bus_write(2'd2, 16'd1);
        run_pixel(10'd0, 10'd0, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_oh !== 1'b0 || r_cs !== 1'b0) begin
            errors++;
            $display("FAIL rst_staged_only got h=%0b cs=%0b want 0 0", r_oh, r_cs);
        end
        pulse_frame();
        run_pixel(10'd0, 10'd0, r_addr, r_cs, r_ov, r_oh, r_rgb);
        checks++;
        if (r_oh !== 1'b1 || r_addr !== 8'd0 || r_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL rst_reenabled got h=%0b addr=%h rgb=%h want 1 00 ffffff", r_oh, r_addr, r_rgb);
        end
    endtask

    initial begin
        reset          = 1'b1;
        avs_address    = 2'd0;
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        avs_chipselect = 1'b0;
        avs_writedata  = 16'd0;
        frame_start    = 1'b0;
        pix_valid      = 1'b0;
        pix_x          = 10'd0;
        pix_y          = 10'd0;
        rom_word       = 16'h0000;
        rom_readdata   = 16'h0000;

        test_reset();
        test_basic_hit();
        test_key_color();
        test_staging();
        test_right_edge();
        test_back_to_back();
        test_frame_edge_inflight();
        test_reset_inflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
